// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: a + b + cin, LSB first, one full-adder slice, one bit per clock.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.
module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] sa, sb;
    logic [WIDTH-1:0] psum_w;
    logic             carry, s_bit, c_nx;
    logic [CW-1:0]    cnt;
    logic             last, load;

    assign s_bit = sa[0] ^ sb[0] ^ carry;
    assign c_nx  = (sa[0] & sb[0]) | (carry & (sa[0] ^ sb[0]));
    assign last  = (cnt == CW'(WIDTH - 1));
    assign load  = start && ((state == IDLE) || (state == DONE));

    // psum_w is the partial-sum window after the current bit is shifted in;
    // only its upper WIDTH-1 bits need storage since the LSB slot is refilled each cycle.
    generate
        if (WIDTH == 1) begin : g_w1
            assign psum_w = s_bit;
        end else begin : g_wn
            logic [WIDTH-2:0] psum;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    psum <= '0;
                end else if (state == RUN) begin
                    psum <= psum_w[WIDTH-1:1];
                end
            end
            assign psum_w = {s_bit, psum};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last)  state_nx = DONE;
            DONE:    state_nx = start ? RUN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa    <= '0;
            sb    <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (load) begin
            sa    <= a;
            sb    <= b;
            carry <= cin;
            cnt   <= '0;
        end else if (state == RUN) begin
            sa    <= sa >> 1;
            sb    <= sb >> 1;
            carry <= c_nx;
            cnt   <= cnt + 1'b1;
            if (last) begin
                sum  <= psum_w;
                cout <= c_nx;
            end
        end
    end

`ifdef SERIAL_ADD_OVF_EN
    // On the final bit the carry register holds the carry into the MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if ((state == RUN) && last) begin
            ovf <= carry ^ c_nx;
        end
    end
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8): vector table, corner sequences, random ops.
module tb_serial_add_ctrl;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n, start, cin;
    logic [W-1:0] a, b;
    logic         busy, done, cout;
    logic [W-1:0] sum;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;
`endif

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [W-1:0] m_sum;
    logic         m_cout;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ovf(input string name, input logic exp);
`ifdef SERIAL_ADD_OVF_EN
        chk(name, ovf, exp);
`else
        if (exp === 1'bx) $display("unused %s", name);
`endif
    endtask

    // Wait (bounded) for done, checking busy and held result on every RUN cycle.
    task automatic wait_done(input string tag, input int start_lat, input bit scramble, output int lat);
        lat = start_lat;
        while (done !== 1'b1 && lat < 30) begin
            chk({tag, "/busy"}, busy, 1);
            chk({tag, "/hold"}, {cout, sum}, {m_cout, m_sum});
            if (scramble) begin
                a   = 8'($urandom);
                b   = 8'($urandom);
                cin = 1'($urandom);
            end
            step();
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic icin, input logic [W-1:0] es, input logic ec, input logic eo);
        int lat;
        a = ia; b = ib; cin = icin; start = 1'b1;
        step();
        start = 1'b0;
        wait_done(tag, 0, 1'b1, lat);
        chk({tag, "/lat"}, lat, W);
        chk({tag, "/busy_at_done"}, busy, 0);
        chk({tag, "/sum"}, sum, es);
        chk({tag, "/cout"}, cout, ec);
        chk_ovf({tag, "/ovf"}, eo);
        m_sum = es; m_cout = ec;
        step();
        chk({tag, "/done_pulse"}, done, 0);
        chk({tag, "/idle"}, busy, 0);
        chk({tag, "/sum_held"}, {cout, sum}, {m_cout, m_sum});
    endtask

    initial begin
        int lat, lat2;
        logic [W-1:0] ra, rb, es;
        logic rc, ec, eo;

        tbl[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[1] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        tbl[2] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        tbl[3] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0};
        tbl[4] = '{8'h0F, 8'hF0, 1'b1, 8'h00, 1'b1, 1'b0};
        tbl[5] = '{8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0};
        tbl[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        tbl[7] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
        tbl[8] = '{8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1};

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset/busy", busy, 0);
        chk("reset/done", done, 0);
        chk("reset/sum", sum, 0);
        chk("reset/cout", cout, 0);
        chk_ovf("reset/ovf", 1'b0);
        rst_n = 1'b1;
        m_sum = '0; m_cout = 1'b0;
        repeat (3) step();
        chk("idle_hold/busy", busy, 0);
        chk("idle_hold/done", done, 0);

        for (int i = 0; i < 9; i++)
            run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].s, tbl[i].co, tbl[i].ov);

        // start during RUN is ignored and operands are not resampled
        a = 8'h12; b = 8'h34; cin = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        step(); step();
        start = 1'b1; a = 8'hFF; b = 8'hFF;
        step();
        start = 1'b0;
        wait_done("ign", 3, 1'b0, lat);
        chk("ign/lat", lat, W);
        chk("ign/sum", sum, 8'h47);
        chk("ign/cout", cout, 0);
        m_sum = 8'h47; m_cout = 1'b0;
        step();
        chk("ign/no_second", busy, 0);
        chk("ign/done_off", done, 0);

        // back-to-back with start held through DONE
        a = 8'h0F; b = 8'hF0; cin = 1'b1; start = 1'b1;
        step();
        wait_done("b2b1", 0, 1'b0, lat);
        chk("b2b1/lat", lat, W);
        chk("b2b1/sum", sum, 8'h00);
        chk("b2b1/cout", cout, 1);
        m_sum = 8'h00; m_cout = 1'b1;
        step();
        chk("b2b/rerun_busy", busy, 1);
        chk("b2b/rerun_done", done, 0);
        start = 1'b0;
        wait_done("b2b2", 1, 1'b0, lat2);
        chk("b2b2/spacing", lat2, W + 1);
        chk("b2b2/sum", sum, 8'h00);
        chk("b2b2/cout", cout, 1);
        step();
        chk("b2b2/idle", busy, 0);

        // asynchronous reset in the middle of an operation
        a = 8'h55; b = 8'h22; cin = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        chk("rst/busy_before", busy, 1);
        #3 rst_n = 1'b0;
        #1;
        chk("rst/busy", busy, 0);
        chk("rst/done", done, 0);
        chk("rst/sum", sum, 0);
        chk("rst/cout", cout, 0);
        chk_ovf("rst/ovf", 1'b0);
        repeat (2) begin
            step();
            chk("rst/held_done", done, 0);
            chk("rst/held_busy", busy, 0);
        end
        rst_n = 1'b1;
        m_sum = '0; m_cout = 1'b0;
        repeat (12) begin
            step();
            chk("rst/no_done", done, 0);
            chk("rst/no_result", {cout, sum}, 9'h000);
        end
        run_op("post_rst", 8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0);

        // random operations against an arithmetic model
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            {ec, es} = 9'(ra) + 9'(rb) + 9'(rc);
            eo = (ra[W-1] == rb[W-1]) && (es[W-1] != ra[W-1]);
            run_op("rand", ra, rb, rc, es, ec, eo);
            repeat ($urandom_range(0, 3)) step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
